// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM with memory-wait timeout and retire counter.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        BranchNE,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALUop,
  output logic        err,
  output logic [15:0] retired
);
  localparam int WW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTEXE, RTWB, ADDIEXE, ADDIWB, BRANCH, ERROR
  } state_t;
  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]   retired_q, retired_d;
  logic          mem_st, timeout;
  assign mem_st  = state_q inside {FETCH, MEMRD, MEMWR};
  assign timeout = mem_st && !mem_ready && (wait_cnt_q == WW'(MAX_WAIT));
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      INIT:    state_d = FETCH;
      FETCH:   state_d = mem_ready ? DECODE : timeout ? ERROR : FETCH;
      DECODE: begin
        op_d    = opcode;
        state_d = (opcode == 6'b100011 || opcode == 6'b101011) ? MEMADR :
                  (opcode == 6'b000000) ? RTEXE :
                  (opcode == 6'b001000) ? ADDIEXE :
                  (opcode == 6'b000100 || opcode == 6'b000101) ? BRANCH : ERROR;
      end
      MEMADR:  state_d = (op_q == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : timeout ? ERROR : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : timeout ? ERROR : MEMWR;
      MEMWB, RTWB, ADDIWB, BRANCH: state_d = FETCH;
      RTEXE:   state_d = RTWB;
      ADDIEXE: state_d = ADDIWB;
      default: state_d = ERROR;
    endcase
  end
  // wait_cnt only survives while a memory state is held waiting; any exit or entry clears it
  assign wait_cnt_d = (mem_st && !mem_ready && !timeout) ? wait_cnt_q + WW'(1) : '0;
  assign retired_d  = retired_q + 16'(state_d == FETCH &&
                      state_q inside {MEMWB, MEMWR, RTWB, ADDIWB, BRANCH});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      op_q       <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end
  assign retired = retired_q;
  always_comb begin
    {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, BranchNE,
     RegWrite, RegDst, MemtoReg, ALUSrcA, err} = '0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUop    = 3'b000;
    case (state_q)
      FETCH: begin
        {mem_req, MemRead} = 2'b11;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE:          ALUSrcB = 2'b11;
      MEMADR, ADDIEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:  {mem_req, MemRead, IorD} = 3'b111;
      MEMWB:  {RegWrite, MemtoReg} = 2'b11;
      MEMWR:  {mem_req, MemWrite, IorD} = 3'b111;
      RTEXE: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b010;
      end
      RTWB:   {RegWrite, RegDst} = 2'b11;
      ADDIWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (op_q == 6'b000101);
      end
      ERROR:  err = 1'b1;
      default: ;
    endcase
  end
endmodule
